// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage buffers: counter type, NOP encoding,
// flush source identifiers and the pointer-width helper.
package pipe_pkg;

  localparam int PIPE_FIFO_MAX_DEPTH = 8;

  typedef logic [$clog2(PIPE_FIFO_MAX_DEPTH + 1)-1:0] type_pipe_fifo_cnt_t;

  localparam logic [31:0] INSTR_NOP       = 32'h0000_0013;
  localparam logic [63:0] PIPE_RESET_DATA = {32'h0000_0000, INSTR_NOP};

  typedef enum logic [1:0] {
    FLUSH_SRC_NONE   = 2'd0,
    FLUSH_SRC_BRANCH = 2'd1,
    FLUSH_SRC_EXCEPT = 2'd2,
    FLUSH_SRC_IRQ    = 2'd3
  } flush_src_e;

  // A single-entry buffer still needs a 1-bit pointer to index its storage.
  function automatic int pipe_ptr_w(input int depth);
    int w;
    if (depth > 1) begin
      w = $clog2(depth);
    end else begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/pipe_fifo_ptr.sv
// Read/write pointers and occupancy count for a circular buffer of any DEPTH;
// pointers wrap explicitly so non-power-of-2 depths work.
module pipe_fifo_ptr
  import pipe_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = pipe_ptr_w(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W-1:0] rd_ptr_nxt,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p == PTR_W'(DEPTH - 1)) begin
      r = {PTR_W{1'b0}};
    end else begin
      r = p + PTR_W'(1'b1);
    end
    return r;
  endfunction

  // Pointer and count update; flush empties the buffer by catching rd up to wr.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= wr_ptr_r;
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wrap_inc(wr_ptr_r);
      end
      if (pop) begin
        rd_ptr_r <= wrap_inc(rd_ptr_r);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Next read position, used to prefetch the following head entry on a pop.
  always_comb begin
    rd_ptr_nxt = wrap_inc(rd_ptr_r);
  end

  assign wr_ptr = wr_ptr_r;
  assign rd_ptr = rd_ptr_r;
  assign count  = count_r;

endmodule

// File: rtl/pipe_stage_fifo_chk.sv
// Protocol and occupancy invariants for pipe_stage_fifo, observed purely from its ports.
module pipe_stage_fifo_chk
  import pipe_pkg::*;
#(
  parameter  int DEPTH  = 2,
  parameter  int CTRL_W = 16,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input logic              clk,
  input logic              rst,
  input logic              in_valid,
  input logic              in_ready,
  input logic              out_valid,
  input logic              out_ready,
  input logic              stall,
  input logic              flush,
  input logic [CTRL_W-1:0] out_ctrl,
  input logic [CNT_W-1:0]  count
);

  logic                push_s;
  logic                pop_s;
  logic                full_s;
  type_pipe_fifo_cnt_t count_ext_s;

  // Handshake terms reconstructed from the port view.
  always_comb begin
    push_s      = in_valid & in_ready;
    pop_s       = out_valid & out_ready & ~stall & ~flush;
    full_s      = (count == CNT_W'(DEPTH));
    count_ext_s = type_pipe_fifo_cnt_t'(count);
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(push_s && full_s && !pop_s))
    else $error("pipe_stage_fifo_chk: push accepted into a full buffer without a pop");

  a_count_range : assert property (@(posedge clk) disable iff (rst) count_ext_s <= type_pipe_fifo_cnt_t'(DEPTH))
    else $error("pipe_stage_fifo_chk: count exceeds DEPTH");

  a_ctrl_known : assert property (@(posedge clk) disable iff (rst) out_valid |-> !$isunknown(out_ctrl))
    else $error("pipe_stage_fifo_chk: unknown out_ctrl while out_valid");

endmodule

// File: rtl/pipe_stage_fifo.sv
// Reusable inter-stage pipeline buffer: DEPTH=1 is a plain stage register, larger
// depths give an elastic skid FIFO. Head data/ctrl are registered, no in->out path.
module pipe_stage_fifo
  import pipe_pkg::*;
#(
  parameter  int                DATA_W     = 64,
  parameter  int                CTRL_W     = 16,
  parameter  int                DEPTH      = 2,
  parameter  logic [DATA_W-1:0] RESET_DATA = DATA_W'(PIPE_RESET_DATA),
  localparam int                PTR_W      = pipe_ptr_w(DEPTH),
  localparam int                CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_flushed,
  input  logic              stall,
  input  logic              flush,
  output logic [CNT_W-1:0]  count
);

  logic [PTR_W-1:0]  wr_ptr_s;
  logic [PTR_W-1:0]  rd_ptr_s;
  logic [PTR_W-1:0]  rd_ptr_nxt_s;
  logic [CNT_W-1:0]  count_s;
  logic              full_s;
  logic              in_ready_s;
  logic              push_s;
  logic              pop_s;

  logic [DATA_W-1:0] mem_data_r [DEPTH];
  logic [CTRL_W-1:0] mem_ctrl_r [DEPTH];
  logic [DATA_W-1:0] head_data_r;
  logic [CTRL_W-1:0] head_ctrl_r;
  logic              out_valid_r;
  logic              out_flushed_r;

  // Handshake: a full buffer still accepts when the head leaves in the same cycle.
  always_comb begin
    full_s     = (count_s == CNT_W'(DEPTH));
    in_ready_s = ~rst & ~stall & ~flush & (~full_s | out_ready);
    push_s     = in_valid & in_ready_s;
    pop_s      = out_valid_r & out_ready & ~stall & ~flush;
  end

  pipe_fifo_ptr #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .pop        (pop_s),
    .flush      (flush),
    .wr_ptr     (wr_ptr_s),
    .rd_ptr     (rd_ptr_s),
    .rd_ptr_nxt (rd_ptr_nxt_s),
    .count      (count_s)
  );

  // Entry storage, written at the tail on every accepted push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_r[i] <= {DATA_W{1'b0}};
        mem_ctrl_r[i] <= {CTRL_W{1'b0}};
      end
    end else if (push_s) begin
      mem_data_r[wr_ptr_s] <= in_data;
      mem_ctrl_r[wr_ptr_s] <= in_ctrl;
    end else begin
      mem_data_r[wr_ptr_s] <= mem_data_r[wr_ptr_s];
      mem_ctrl_r[wr_ptr_s] <= mem_ctrl_r[wr_ptr_s];
    end
  end

  // Head register: tracks the oldest entry and keeps the last data once empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_data_r   <= RESET_DATA;
      head_ctrl_r   <= {CTRL_W{1'b0}};
      out_valid_r   <= 1'b0;
      out_flushed_r <= 1'b0;
    end else if (flush) begin
      head_ctrl_r   <= {CTRL_W{1'b0}};
      out_valid_r   <= 1'b0;
      out_flushed_r <= 1'b1;
    end else begin
      if (push_s) begin
        out_flushed_r <= 1'b0;
      end
      case ({push_s, pop_s})
        2'b10: begin
          if (!out_valid_r) begin
            head_data_r <= in_data;
            head_ctrl_r <= in_ctrl;
            out_valid_r <= 1'b1;
          end
        end
        2'b01: begin
          if (count_s == CNT_W'(1'b1)) begin
            head_ctrl_r <= {CTRL_W{1'b0}};
            out_valid_r <= 1'b0;
          end else begin
            head_data_r <= mem_data_r[rd_ptr_nxt_s];
            head_ctrl_r <= mem_ctrl_r[rd_ptr_nxt_s];
          end
        end
        2'b11: begin
          // With a single entry the incoming word becomes the new head directly.
          if (count_s == CNT_W'(1'b1)) begin
            head_data_r <= in_data;
            head_ctrl_r <= in_ctrl;
          end else begin
            head_data_r <= mem_data_r[rd_ptr_nxt_s];
            head_ctrl_r <= mem_ctrl_r[rd_ptr_nxt_s];
          end
        end
        default: begin
          head_data_r <= head_data_r;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_r;
  assign out_data    = head_data_r;
  assign out_ctrl    = head_ctrl_r;
  assign out_flushed = out_flushed_r;
  assign count       = count_s;

  pipe_stage_fifo_chk #(
    .DEPTH  (DEPTH),
    .CTRL_W (CTRL_W)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s),
    .out_valid (out_valid_r),
    .out_ready (out_ready),
    .stall     (stall),
    .flush     (flush),
    .out_ctrl  (head_ctrl_r),
    .count     (count_s)
  );

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Bench for pipe_stage_fifo at DEPTH 1,2,3,5,8: directed scenarios plus random traffic,
// all instances checked every cycle against a queue-based model of the buffer.
module tb_pipe_stage_fifo;

  localparam int          NI       = 5;
  localparam logic [63:0] RST_DATA = 64'h0000_0000_0000_0013;

  function automatic int depth_of(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      3:       return 5;
      default: return 8;
    endcase
  endfunction

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NI-1:0] in_valid_v  = '0;
  logic [NI-1:0] out_ready_v = '0;
  logic [NI-1:0] stall_v     = '0;
  logic [NI-1:0] flush_v     = '0;
  logic [NI-1:0] in_ready_v;
  logic [NI-1:0] out_valid_v;
  logic [NI-1:0] out_flushed_v;
  logic [63:0]   in_data_a   [NI];
  logic [15:0]   in_ctrl_a   [NI];
  logic [63:0]   out_data_a  [NI];
  logic [15:0]   out_ctrl_a  [NI];
  logic [3:0]    count_a     [NI];

  // Reference model: one queue of {ctrl,data} per instance
  logic [79:0]   mq      [NI][$];
  logic [63:0]   last_d  [NI];
  bit            flushed_m [NI];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D = depth_of(g);
    logic [$clog2(D+1)-1:0] cnt_w;
    pipe_stage_fifo #(
      .DATA_W     (64),
      .CTRL_W     (16),
      .DEPTH      (D),
      .RESET_DATA (RST_DATA)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid_v[g]),
      .in_ready    (in_ready_v[g]),
      .in_data     (in_data_a[g]),
      .in_ctrl     (in_ctrl_a[g]),
      .out_valid   (out_valid_v[g]),
      .out_ready   (out_ready_v[g]),
      .out_data    (out_data_a[g]),
      .out_ctrl    (out_ctrl_a[g]),
      .out_flushed (out_flushed_v[g]),
      .stall       (stall_v[g]),
      .flush       (flush_v[g]),
      .count       (cnt_w)
    );
    assign count_a[g] = 4'(cnt_w);
  end

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, idx, act, exp, $time);
    end
  endtask

  function automatic bit exp_in_ready(input int i);
    int sz;
    sz = mq[i].size();
    return !rst && !stall_v[i] && !flush_v[i] &&
           ((sz < depth_of(i)) || (sz == depth_of(i) && out_ready_v[i]));
  endfunction

  task automatic model_update(input int i, input bit rdy);
    logic [79:0] h;
    bit pop;
    bit push;
    if (rst) begin
      mq[i].delete();
      last_d[i]    = RST_DATA;
      flushed_m[i] = 1'b0;
    end else if (flush_v[i]) begin
      if (mq[i].size() > 0) begin
        h = mq[i][0];
        last_d[i] = h[63:0];
      end
      mq[i].delete();
      flushed_m[i] = 1'b1;
    end else begin
      pop  = (mq[i].size() > 0) && out_ready_v[i] && !stall_v[i];
      push = in_valid_v[i] && rdy;
      if (pop) begin
        h = mq[i].pop_front();
        last_d[i] = h[63:0];
      end
      if (push) begin
        mq[i].push_back({in_ctrl_a[i], in_data_a[i]});
        flushed_m[i] = 1'b0;
      end
    end
  endtask

  // One clock: check in_ready, advance model at posedge, compare outputs at negedge.
  task automatic step();
    bit rdy_e [NI];
    logic [79:0] h;
    int sz;
    #1;
    for (int i = 0; i < NI; i++) begin
      rdy_e[i] = exp_in_ready(i);
      chk("in_ready", i, 64'(in_ready_v[i]), 64'(rdy_e[i]));
    end
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_update(i, rdy_e[i]);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      sz = mq[i].size();
      if (sz > 0) h = mq[i][0];
      else        h = {16'h0000, last_d[i]};
      chk("out_valid",   i, 64'(out_valid_v[i]),   64'(sz > 0));
      chk("out_data",    i, out_data_a[i],         h[63:0]);
      chk("out_ctrl",    i, 64'(out_ctrl_a[i]),    64'(h[79:64]));
      chk("count",       i, 64'(count_a[i]),       64'(sz));
      chk("out_flushed", i, 64'(out_flushed_v[i]), 64'(flushed_m[i]));
    end
  endtask

  task automatic set_idle();
    in_valid_v  = '0;
    out_ready_v = '0;
    stall_v     = '0;
    flush_v     = '0;
    for (int i = 0; i < NI; i++) begin
      in_data_a[i] = 64'h0;
      in_ctrl_a[i] = 16'h0;
    end
  endtask

  task automatic push_one(input int i, input logic [63:0] d, input logic [15:0] c);
    in_valid_v[i] = 1'b1;
    in_data_a[i]  = d;
    in_ctrl_a[i]  = c;
    step();
    in_valid_v[i] = 1'b0;
  endtask

  initial begin
    int or_thr;
    int iv_thr;
    for (int i = 0; i < NI; i++) begin
      last_d[i]    = RST_DATA;
      flushed_m[i] = 1'b0;
    end
    set_idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state, DEPTH=1 stage register
    chk("rst_out_data",  0, out_data_a[0], 64'h13);
    chk("rst_out_valid", 0, 64'(out_valid_v[0]), 64'd0);
    chk("rst_count",     0, 64'(count_a[0]), 64'd0);
    push_one(0, 64'h1000, 16'h5);
    chk("d1_out_valid", 0, 64'(out_valid_v[0]), 64'd1);
    chk("d1_out_data",  0, out_data_a[0], 64'h1000);
    chk("d1_out_ctrl",  0, 64'(out_ctrl_a[0]), 64'h5);
    chk("d1_count",     0, 64'(count_a[0]), 64'd1);
    out_ready_v[0] = 1'b1;
    step();
    set_idle();

    // DEPTH=3 fill, full-throughput pop+push, drain across wrap
    push_one(2, 64'hA, 16'h1);
    push_one(2, 64'hB, 16'h2);
    push_one(2, 64'hC, 16'h3);
    chk("d3_count_full", 2, 64'(count_a[2]), 64'd3);
    chk("model_size",    2, 64'(mq[2].size()), 64'd3);
    in_valid_v[2] = 1'b1; in_data_a[2] = 64'hD; in_ctrl_a[2] = 16'h4;
    #1 chk("d3_full_not_ready", 2, 64'(in_ready_v[2]), 64'd0);
    out_ready_v[2] = 1'b1;
    #1 chk("d3_full_ready_pop", 2, 64'(in_ready_v[2]), 64'd1);
    step();
    chk("d3_count_swap", 2, 64'(count_a[2]), 64'd3);
    chk("d3_head_b",     2, out_data_a[2], 64'hB);
    in_valid_v[2] = 1'b0;
    step();
    chk("d3_head_c", 2, out_data_a[2], 64'hC);
    step();
    chk("d3_head_d", 2, out_data_a[2], 64'hD);
    chk("d3_ctrl_d", 2, 64'(out_ctrl_a[2]), 64'h4);
    step();
    chk("d3_empty_valid", 2, 64'(out_valid_v[2]), 64'd0);
    chk("d3_empty_hold",  2, out_data_a[2], 64'hD);
    chk("d3_empty_ctrl",  2, 64'(out_ctrl_a[2]), 64'h0);
    set_idle();

    // DEPTH=2 stall freezes everything
    push_one(1, 64'h11, 16'h11);
    push_one(1, 64'h22, 16'h22);
    stall_v[1] = 1'b1; out_ready_v[1] = 1'b1;
    in_valid_v[1] = 1'b1; in_data_a[1] = 64'h99;
    #1 chk("stall_in_ready", 1, 64'(in_ready_v[1]), 64'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("stall_head",  1, out_data_a[1], 64'h11);
      chk("stall_count", 1, 64'(count_a[1]), 64'd2);
    end
    stall_v[1] = 1'b0; in_valid_v[1] = 1'b0;
    step();
    chk("unstall_pop",   1, out_data_a[1], 64'h22);
    chk("unstall_count", 1, 64'(count_a[1]), 64'd1);
    step();
    set_idle();

    // DEPTH=2 flush beats stall and push
    push_one(1, 64'h33, 16'h7);
    flush_v[1] = 1'b1; stall_v[1] = 1'b1;
    in_valid_v[1] = 1'b1; in_data_a[1] = 64'h44; in_ctrl_a[1] = 16'h8;
    step();
    set_idle();
    chk("flush_count",   1, 64'(count_a[1]), 64'd0);
    chk("flush_valid",   1, 64'(out_valid_v[1]), 64'd0);
    chk("flush_ctrl",    1, 64'(out_ctrl_a[1]), 64'h0);
    chk("flush_flag",    1, 64'(out_flushed_v[1]), 64'd1);
    chk("flush_data",    1, out_data_a[1], 64'h33);
    step();
    chk("flush_flag_hold", 1, 64'(out_flushed_v[1]), 64'd1);
    push_one(1, 64'h55, 16'h9);
    chk("flush_flag_clr", 1, 64'(out_flushed_v[1]), 64'd0);
    chk("post_flush_data", 1, out_data_a[1], 64'h55);
    out_ready_v[1] = 1'b1;
    step();
    set_idle();

    // Reset mid-stream
    push_one(1, 64'h66, 16'h1);
    push_one(1, 64'h77, 16'h2);
    chk("pre_rst_count", 1, 64'(count_a[1]), 64'd2);
    rst = 1'b1;
    step();
    chk("rst_mid_count",   1, 64'(count_a[1]), 64'd0);
    chk("rst_mid_valid",   1, 64'(out_valid_v[1]), 64'd0);
    chk("rst_mid_data",    1, out_data_a[1], RST_DATA);
    chk("rst_mid_flushed", 1, 64'(out_flushed_v[1]), 64'd0);
    rst = 1'b0;
    out_ready_v[1] = 1'b1;
    step();
    chk("post_rst_valid", 1, 64'(out_valid_v[1]), 64'd0);
    set_idle();

    // Random traffic on all depths, with phases biased toward full or empty
    for (int cyc = 0; cyc < 10000; cyc++) begin
      or_thr = ((cyc / 500) % 4) * 30 + 5;
      iv_thr = 95 - ((cyc / 700) % 4) * 25;
      rst = ($urandom_range(0, 999) == 0);
      for (int i = 0; i < NI; i++) begin
        in_valid_v[i]  = ($urandom_range(0, 99) < iv_thr);
        out_ready_v[i] = ($urandom_range(0, 99) < or_thr);
        stall_v[i]     = ($urandom_range(0, 99) < 8);
        flush_v[i]     = ($urandom_range(0, 99) < 3);
        in_data_a[i]   = {$urandom(), $urandom()};
        in_ctrl_a[i]   = 16'($urandom());
      end
      step();
    end
    rst = 1'b0;
    set_idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
